// File: rtl/ula_pkg.sv
// Shared opcodes, FSM states and datapath modes for the multi-cycle ULA.
package ula_pkg;

    localparam logic [3:0] OP_SOMA = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MOD  = 4'b1010;

    localparam logic MODO_MUL = 1'b0;
    localparam logic MODO_DIV = 1'b1;

    typedef enum logic {
        OCIOSO = 1'b0,
        CALC   = 1'b1
    } estado_t;

endpackage

// File: rtl/ula_muldiv.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per clock.
// Outputs are the values the current iteration produces, so they are final while fim=1.
module ula_muldiv
    import ula_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               carga,
    input  logic               modo,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] produto,
    output logic [WIDTH-1:0]   quociente,
    output logic [WIDTH-1:0]   resto,
    output logic               fim
);

    localparam int CW = $clog2(WIDTH);

    logic               ativo;
    logic               modo_r;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   div_r;
    logic [WIDTH:0]     desloc;
    logic [WIDTH:0]     dif;
    logic               cabe;

    // Dividend bits enter the partial remainder MSB first through quo_r.
    assign desloc    = {rem_r, quo_r[WIDTH-1]};
    assign dif       = desloc - {1'b0, div_r};
    assign cabe      = ~dif[WIDTH];
    assign resto     = cabe ? dif[WIDTH-1:0] : desloc[WIDTH-1:0];
    assign quociente = {quo_r[WIDTH-2:0], cabe};
    assign produto   = acc + (mplier[0] ? mcand : '0);
    assign fim       = ativo && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ativo  <= 1'b0;
            modo_r <= MODO_MUL;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem_r  <= '0;
            quo_r  <= '0;
            div_r  <= '0;
        end else if (carga) begin
            ativo  <= 1'b1;
            modo_r <= modo;
            cnt    <= CW'(WIDTH - 1);
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            rem_r  <= '0;
            quo_r  <= a;
            div_r  <= b;
        end else if (ativo) begin
            if (modo_r == MODO_MUL) begin
                acc    <= produto;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end else begin
                rem_r <= resto;
                quo_r <= quociente;
            end
            if (cnt == '0) ativo <= 1'b0;
            else           cnt   <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Registered ULA: single-cycle logic/arith ops plus iterative mul/div/mod.
// Handshake: inicio is taken on an edge where ocupado=0; valido pulses one cycle when saida/erro/zero update.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inicio,
    input  logic [3:0]         switchs,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] saida,
    output logic               valido,
    output logic               ocupado,
    output logic               erro,
    output logic               zero
);

    localparam int SH = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    estado_t         estado, estado_nx;
    logic [3:0]      op_r;
    logic [W2-1:0]   a_ext, b_ext, res_sc, res_nx;
    logic [SH:0]     desl;
    logic            erro_sc, erro_nx, multi, carga, ld;
    logic [W2-1:0]   produto;
    logic [WIDTH-1:0] quociente, resto;
    logic            fim;

    assign a_ext   = {{WIDTH{1'b0}}, A};
    assign b_ext   = {{WIDTH{1'b0}}, B};
    assign desl    = B[SH:0];
    assign ocupado = (estado == CALC);

    always_comb begin
        res_sc  = '0;
        erro_sc = 1'b0;
        multi   = 1'b0;
        case (switchs)
            OP_SOMA: res_sc = a_ext + b_ext;
            OP_SUB:  res_sc = a_ext - b_ext;
            OP_AND:  res_sc = a_ext & b_ext;
            OP_OR:   res_sc = a_ext | b_ext;
            OP_XOR:  res_sc = a_ext ^ b_ext;
            OP_NOT:  res_sc = {{WIDTH{1'b0}}, ~A};
            OP_SHL:  res_sc = a_ext << desl;
            OP_SHR:  res_sc = a_ext >> desl;
            OP_MUL:  multi  = 1'b1;
            OP_DIV, OP_MOD: begin
                // A zero divisor never enters the iterative path.
                if (B == '0) begin
                    res_sc  = '1;
                    erro_sc = 1'b1;
                end else begin
                    multi = 1'b1;
                end
            end
            default: erro_sc = 1'b1;
        endcase
    end

    ula_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .carga     (carga),
        .modo      ((switchs == OP_MUL) ? MODO_MUL : MODO_DIV),
        .a         (A),
        .b         (B),
        .produto   (produto),
        .quociente (quociente),
        .resto     (resto),
        .fim       (fim)
    );

    always_comb begin
        estado_nx = estado;
        carga     = 1'b0;
        ld        = 1'b0;
        res_nx    = '0;
        erro_nx   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (inicio) begin
                    if (multi) begin
                        carga     = 1'b1;
                        estado_nx = CALC;
                    end else begin
                        ld      = 1'b1;
                        res_nx  = res_sc;
                        erro_nx = erro_sc;
                    end
                end
            end
            CALC: begin
                if (fim) begin
                    ld        = 1'b1;
                    estado_nx = OCIOSO;
                    case (op_r)
                        OP_MUL:  res_nx = produto;
                        OP_DIV:  res_nx = {resto, quociente};
                        default: res_nx = {{WIDTH{1'b0}}, resto};
                    endcase
                end
            end
            default: estado_nx = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
            op_r   <= OP_SOMA;
            saida  <= '0;
            valido <= 1'b0;
            erro   <= 1'b0;
            zero   <= 1'b1;
        end else begin
            estado <= estado_nx;
            valido <= ld;
            if (carga) op_r <= switchs;
            if (ld) begin
                saida <= res_nx;
                erro  <= erro_nx;
                zero  <= (res_nx == '0);
            end
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo at WIDTH=4 and WIDTH=8, checked against an arithmetic reference model.
module tb_ula_multiciclo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       inicio, sel8;
    logic [3:0] switchs;
    logic [7:0] a_in, b_in;

    logic [7:0]  saida4;
    logic        valido4, ocupado4, erro4, zero4;
    logic [15:0] saida8;
    logic        valido8, ocupado8, erro8, zero8;

    logic [15:0] o_saida;
    logic        o_valido, o_ocupado, o_erro, o_zero;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    ula_multiciclo #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio & ~sel8),
        .switchs (switchs),
        .A       (a_in[3:0]),
        .B       (b_in[3:0]),
        .saida   (saida4),
        .valido  (valido4),
        .ocupado (ocupado4),
        .erro    (erro4),
        .zero    (zero4)
    );

    ula_multiciclo #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio & sel8),
        .switchs (switchs),
        .A       (a_in),
        .B       (b_in),
        .saida   (saida8),
        .valido  (valido8),
        .ocupado (ocupado8),
        .erro    (erro8),
        .zero    (zero8)
    );

    assign o_saida   = sel8 ? saida8   : {8'h00, saida4};
    assign o_valido  = sel8 ? valido8  : valido4;
    assign o_ocupado = sel8 ? ocupado8 : ocupado4;
    assign o_erro    = sel8 ? erro8    : erro4;
    assign o_zero    = sel8 ? zero8    : zero4;

    // Returns {erro, saida} for operand width w.
    function automatic logic [16:0] ref_model(int w, int op, int a, int b);
        int m2 = (1 << (2 * w)) - 1;
        int m  = (1 << w) - 1;
        int sh = b % (2 * w);
        int r  = 0;
        logic e = 1'b0;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = (~a) & m;
            6:  r = a << sh;
            7:  r = a >> sh;
            8:  r = a * b;
            9:  if (b == 0) begin r = m2; e = 1'b1; end
                else r = ((a % b) << w) | (a / b);
            10: if (b == 0) begin r = m2; e = 1'b1; end
                else r = a % b;
            default: begin r = 0; e = 1'b1; end
        endcase
        return {e, 16'(r & m2)};
    endfunction

    function automatic int ref_lat(int w, int op, int b);
        if (op == 8 || ((op == 9 || op == 10) && b != 0)) return w;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op on the selected instance and check the whole response.
    task automatic run_op(input int op, input int a, input int b, input string tag);
        int w;
        int n;
        int occ;
        logic [16:0] r;
        w = sel8 ? 8 : 4;
        r = ref_model(w, op, a, b);
        exp_q.push_back(r[15:0]);
        @(negedge clk);
        switchs = 4'(op);
        a_in    = 8'(a);
        b_in    = 8'(b);
        inicio  = 1'b1;
        @(negedge clk);
        inicio  = 1'b0;
        switchs = 4'($urandom);
        a_in    = 8'($urandom);
        b_in    = 8'($urandom);
        n = 0;
        occ = 0;
        while (!o_valido && n < 20) begin
            occ += int'(o_ocupado);
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_valido", tag), 32'(o_valido), 32'd1);
        chk($sformatf("%s_latencia", tag), n, ref_lat(w, op, b));
        chk($sformatf("%s_ocupado_ciclos", tag), occ, ref_lat(w, op, b));
        chk($sformatf("%s_saida", tag), 32'(o_saida), 32'(exp_q.pop_front()));
        chk($sformatf("%s_erro", tag), 32'(o_erro), 32'(r[16]));
        chk($sformatf("%s_zero", tag), 32'(o_zero), 32'(r[15:0] == 16'h0));
        chk($sformatf("%s_ocupado_fim", tag), 32'(o_ocupado), 32'd0);
        @(negedge clk);
        chk($sformatf("%s_pulso", tag), 32'(o_valido), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int extra;
        int w;
        int op;
        int a;
        int b;
        logic [16:0] r;

        sel8 = 1'b0; inicio = 1'b0; switchs = 4'h0; a_in = 8'h0; b_in = 8'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_saida4", 32'(saida4), 32'd0);
        chk("rst_valido4", 32'(valido4), 32'd0);
        chk("rst_ocupado4", 32'(ocupado4), 32'd0);
        chk("rst_erro4", 32'(erro4), 32'd0);
        chk("rst_zero4", 32'(zero4), 32'd1);
        chk("rst_saida8", 32'(saida8), 32'd0);
        chk("rst_zero8", 32'(zero8), 32'd1);
        rst_n = 1'b1;

        run_op(0, 15, 15, "add_15_15");

        // Back-to-back single-cycle subtractions.
        @(negedge clk);
        switchs = 4'd1; a_in = 8'd8; b_in = 8'd4; inicio = 1'b1;
        @(negedge clk);
        r = ref_model(4, 1, 8, 4);
        chk("sub_b2b_1_valido", 32'(o_valido), 32'd1);
        chk("sub_b2b_1_saida", 32'(o_saida), 32'(r[15:0]));
        a_in = 8'd1; b_in = 8'd2;
        @(negedge clk);
        r = ref_model(4, 1, 1, 2);
        chk("sub_b2b_2_valido", 32'(o_valido), 32'd1);
        chk("sub_b2b_2_saida", 32'(o_saida), 32'(r[15:0]));
        chk("sub_b2b_2_erro", 32'(o_erro), 32'd0);
        inicio = 1'b0;
        @(negedge clk);
        chk("sub_b2b_fim", 32'(o_valido), 32'd0);

        // Multiply with inicio held during the busy phase.
        @(negedge clk);
        switchs = 4'd8; a_in = 8'd15; b_in = 8'd15; inicio = 1'b1;
        @(negedge clk);
        chk("mul_busy_ocupado", 32'(o_ocupado), 32'd1);
        switchs = 4'd0; a_in = 8'd1; b_in = 8'd1;
        @(negedge clk);
        inicio = 1'b0;
        n = 1;
        while (!o_valido && n < 20) begin
            @(negedge clk);
            n++;
        end
        r = ref_model(4, 8, 15, 15);
        chk("mul_busy_latencia", n, 32'd4);
        chk("mul_busy_saida", 32'(o_saida), 32'(r[15:0]));
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            extra += int'(o_valido);
        end
        chk("mul_busy_sem_extra", extra, 32'd0);

        run_op(9, 13, 3, "div_13_3");
        run_op(10, 13, 3, "mod_13_3");
        run_op(9, 13, 0, "div_zero");
        run_op(10, 7, 0, "mod_zero");
        run_op(15, 5, 6, "op_indef");
        run_op(0, 0, 0, "add_zero");
        run_op(6, 9, 3, "shl");
        run_op(7, 12, 2, "shr");
        run_op(5, 5, 0, "not");
        run_op(8, 0, 11, "mul_por_zero");

        // Reset in the middle of a multiply.
        @(negedge clk);
        switchs = 4'd8; a_in = 8'd7; b_in = 8'd9; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_meio_saida", 32'(saida4), 32'd0);
        chk("rst_meio_ocupado", 32'(ocupado4), 32'd0);
        chk("rst_meio_valido", 32'(valido4), 32'd0);
        chk("rst_meio_zero", 32'(zero4), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            extra += int'(valido4);
        end
        chk("rst_meio_sem_valido", extra, 32'd0);
        run_op(0, 4, 1, "add_pos_rst");

        sel8 = 1'b1;
        run_op(0, 255, 255, "add8_255");
        run_op(8, 255, 255, "mul8_255");
        run_op(9, 200, 7, "div8");
        run_op(10, 200, 7, "mod8");
        run_op(1, 3, 200, "sub8_neg");

        for (int i = 0; i < 40; i++) begin
            sel8 = 1'($urandom_range(0, 1));
            w  = sel8 ? 8 : 4;
            op = $urandom_range(0, 15);
            a  = $urandom_range(0, (1 << w) - 1);
            b  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, (1 << w) - 1);
            run_op(op, a, b, $sformatf("rand%0d_w%0d_op%0d", i, w, op));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
Parametrised, registered successor to the team's 4-bit combinational ULA. It keeps the same opcode encoding on `switchs` for the single-cycle operations. It adds iterative multiply, divide and modulo, an inicio/ocupado/valido handshake, and error/zero flags. It sits between the switch/operand front end and the display/result logic, and handles one operation at a time.

Parameters:
WIDTH, 4, operand width in bits; saida is 2*WIDTH bits wide (legal range 2..16).

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
inicio  in  1  start request; sampled only while ocupado=0
switchs  in  4  opcode
A  in  WIDTH  operand A, unsigned
B  in  WIDTH  operand B, unsigned
saida  out  2*WIDTH  registered result; held until the next result
valido  out  1  one-cycle pulse when saida updates
ocupado  out  1  high while a multi-cycle op is running
erro  out  1  registered with saida; high for divide/modulo by zero or an undefined opcode
zero  out  1  registered with saida; high when saida==0

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - saida=0, valido=0, ocupado=0, erro=0, zero=1
  - FSM to OCIOSO
  - A reset mid-operation aborts it; no valido follows.
- Acceptance: rising edge k with inicio=1 and ocupado=0. switchs, A and B are latched at edge k. inicio while ocupado=1 is ignored and does not queue.
- Opcodes and results (unsigned arithmetic, results zero-extended to 2W unless stated):
  - 0000 add: A+B; the carry appears in bit W.
  - 0001 sub: A-B, as 2W-bit two's complement. A<B therefore sign-extends (1-2 = all ones).
  - 0010 and, 0011 or, 0100 xor: bitwise, zero-extended.
  - 0101 not: ~A, zero-extended.
  - 0110 shl: A<<B[log2(W):0], computed in 2W bits.
  - 0111 shr: A>>B[log2(W):0].
  - 1000 mul: A*B, full 2W bits, shift-add, one partial product per cycle.
  - 1001 div: saida = {remainder[W-1:0], quotient[W-1:0]}, restoring algorithm, one bit per cycle.
  - 1010 mod: saida = {W zeros, remainder}; same datapath as div.
  - 1011-1111: saida=0, erro=1, single-cycle.
- Single-cycle ops, including undefined opcodes and divide/modulo by zero:
  - Result is registered at edge k; valido=1 for the cycle after edge k.
  - ocupado stays 0, so back-to-back issue is allowed every cycle.
- Multi-cycle ops (1000/1001/1010 with a valid divisor):
  - FSM moves OCIOSO->CALC at edge k and ocupado=1 from edge k.
  - An iteration counter runs W-1 down to 0, one iteration per edge k+1..k+W.
  - At edge k+W: saida loads the final result, valido=1 for one cycle, ocupado=0, FSM returns to OCIOSO.
  - A new inicio is accepted at edge k+W+1 at the earliest.
- Divide or modulo with B=0: no CALC phase. saida = all ones, erro=1, valido after edge k.
- erro and zero update only on cycles where valido is asserted; otherwise they hold.
- Operand inputs may change freely after acceptance; only the latched copies are used.

Decomposition:
- Package ula_pkg holds:
  - opcode localparams OP_SOMA, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_MUL, OP_DIV, OP_MOD
  - FSM state encodings OCIOSO, CALC
- One sub-module, ula_muldiv: iterative shift-add/restoring-divide datapath.
  - Inputs: clk, rst_n, carga, modo, operands.
  - Outputs: produto/quociente/resto, fim.
- The top level contains the combinational single-cycle ops, the FSM and the output registers.

Test Plan:
- WIDTH=4, op 0000, A=15, B=15, inicio for one cycle -> after the next edge saida=0x1E, valido=1 for one cycle, ocupado=0, zero=0.
- op 0001: A=8, B=4 -> saida=0x04. Then A=1, B=2 -> saida=0xFF, erro=0. Issue both back-to-back -> two consecutive valido pulses.
- op 1000, A=15, B=15 -> ocupado=1 for exactly 4 cycles. valido after the 4th edge following acceptance, saida=0xE1. inicio pulsed while ocupado=1 with op 0000 produces no extra valido.
- op 1001, A=13, B=3 -> saida=0x14 after 4 cycles. Then op 1010, same operands -> saida=0x01. Then op 1001 with B=0 -> saida=0xFF, erro=1, valido one edge after acceptance.
- op 1111 -> saida=0, erro=1, zero=1. Then op 0000 with A=B=0 -> saida=0, erro=0, zero=1.
- Start op 1000 and drop rst_n after 2 cycles -> immediately saida=0, ocupado=0, valido=0. No valido after release. The next op 0000 with A=4, B=1 gives saida=0x05. Repeat the add/mul checks at WIDTH=8: A=255, B=255 -> mul=0xFE01.
